// File: rtl/gpu_pkg.sv
// Shared types and constants for the line rasteriser datapath.
package gpu_pkg;

    localparam int unsigned COORD_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLOT  = 3'd2,
        DONE  = 3'd3,
        REARM = 3'd4
    } line_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pixel_t;

endpackage

// File: rtl/line_delta_calc.sv
// Combinational setup for one Bresenham segment: deltas, step signs, initial error.
module line_delta_calc #(
    parameter int unsigned COORD_W = 8
) (
    input  logic [COORD_W-1:0]        x0_i,
    input  logic [COORD_W-1:0]        y0_i,
    input  logic [COORD_W-1:0]        x1_i,
    input  logic [COORD_W-1:0]        y1_i,
    output logic signed [COORD_W:0]   dx_o,
    output logic signed [COORD_W:0]   dy_o,
    output logic                      sx_neg_o,
    output logic                      sy_neg_o,
    output logic signed [COORD_W+2:0] err_o
);

    localparam int unsigned ERR_W = COORD_W + 3;

    logic [COORD_W-1:0] abs_dx;
    logic [COORD_W-1:0] abs_dy;

    // Absolute spans; dy is carried negated as in the classic all-octant form.
    always_comb begin
        abs_dx   = (x1_i >= x0_i) ? (x1_i - x0_i) : (x0_i - x1_i);
        abs_dy   = (y1_i >= y0_i) ? (y1_i - y0_i) : (y0_i - y1_i);
        dx_o     = $signed({1'b0, abs_dx});
        dy_o     = -$signed({1'b0, abs_dy});
        sx_neg_o = !(x0_i < x1_i);
        sy_neg_o = !(y0_i < y1_i);
        err_o    = ERR_W'(dx_o) + ERR_W'(dy_o);
    end

endmodule

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: takes one segment per draw_en request and
// streams its pixels over a valid/ready handshake, then pulses draw_done.
module bresenham_line_engine
    import gpu_pkg::*;
#(
    parameter int unsigned COORD_W = gpu_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               draw_en,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               pixel_ready,
    output logic               pixel_wr,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               draw_done,
    output logic               busy
);

    localparam int unsigned D_W   = COORD_W + 1;
    localparam int unsigned ERR_W = COORD_W + 3;
    localparam int unsigned E2_W  = COORD_W + 4;

    line_state_t state_q, state_d;

    logic signed [D_W-1:0]   dx_q, dx_d;
    logic signed [D_W-1:0]   dy_q, dy_d;
    logic                    sx_neg_q, sx_neg_d;
    logic                    sy_neg_q, sy_neg_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic [COORD_W-1:0]      cur_x_q, cur_x_d;
    logic [COORD_W-1:0]      cur_y_q, cur_y_d;
    logic [COORD_W-1:0]      end_x_q, end_x_d;
    logic [COORD_W-1:0]      end_y_q, end_y_d;
    logic                    pixel_wr_q, pixel_wr_d;
    logic                    busy_q, busy_d;
    logic                    draw_done_q, draw_done_d;

    logic signed [D_W-1:0]   calc_dx;
    logic signed [D_W-1:0]   calc_dy;
    logic                    calc_sx_neg;
    logic                    calc_sy_neg;
    logic signed [ERR_W-1:0] calc_err;

    logic signed [E2_W-1:0]  e2;
    logic                    step_x;
    logic                    step_y;
    logic signed [ERR_W-1:0] err_add_x;
    logic signed [ERR_W-1:0] err_add_y;
    logic signed [ERR_W-1:0] err_step;
    logic [COORD_W-1:0]      x_step;
    logic [COORD_W-1:0]      y_step;
    logic                    at_end;

    line_delta_calc #(
        .COORD_W (COORD_W)
    ) u_delta (
        .x0_i     (x0),
        .y0_i     (y0),
        .x1_i     (x1),
        .y1_i     (y1),
        .dx_o     (calc_dx),
        .dy_o     (calc_dy),
        .sx_neg_o (calc_sx_neg),
        .sy_neg_o (calc_sy_neg),
        .err_o    (calc_err)
    );

    // One Bresenham step from the current error; both axis updates share e2.
    always_comb begin
        e2        = $signed({err_q, 1'b0});
        step_x    = (e2 >= E2_W'(dy_q));
        step_y    = (e2 <= E2_W'(dx_q));
        err_add_x = step_x ? ERR_W'(dy_q) : ERR_W'(0);
        err_add_y = step_y ? ERR_W'(dx_q) : ERR_W'(0);
        err_step  = err_q + err_add_x + err_add_y;
        x_step    = cur_x_q;
        y_step    = cur_y_q;
        if (step_x) begin
            x_step = sx_neg_q ? (cur_x_q - COORD_W'(1)) : (cur_x_q + COORD_W'(1));
        end
        if (step_y) begin
            y_step = sy_neg_q ? (cur_y_q - COORD_W'(1)) : (cur_y_q + COORD_W'(1));
        end
        at_end    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    end

    // Next-state, datapath load/step and registered output decode.
    always_comb begin
        state_d     = state_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        err_d       = err_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        end_x_d     = end_x_q;
        end_y_d     = end_y_q;

        case (state_q)
            IDLE: begin
                if (draw_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!draw_en) begin
                    state_d = IDLE;
                end else begin
                    dx_d     = calc_dx;
                    dy_d     = calc_dy;
                    sx_neg_d = calc_sx_neg;
                    sy_neg_d = calc_sy_neg;
                    err_d    = calc_err;
                    cur_x_d  = x0;
                    cur_y_d  = y0;
                    end_x_d  = x1;
                    end_y_d  = y1;
                    state_d  = PLOT;
                end
            end
            PLOT: begin
                if (!draw_en) begin
                    state_d = IDLE;
                end else if (pixel_ready) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        err_d   = err_step;
                        cur_x_d = x_step;
                        cur_y_d = y_step;
                    end
                end
            end
            DONE: begin
                state_d = REARM;
            end
            REARM: begin
                if (!draw_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pixel_wr_d  = (state_d == PLOT);
        busy_d      = (state_d == LOAD) || (state_d == PLOT);
        draw_done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dx_q        <= '0;
            dy_q        <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            err_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            pixel_wr_q  <= 1'b0;
            busy_q      <= 1'b0;
            draw_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            err_q       <= err_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            end_x_q     <= end_x_d;
            end_y_q     <= end_y_d;
            pixel_wr_q  <= pixel_wr_d;
            busy_q      <= busy_d;
            draw_done_q <= draw_done_d;
        end
    end

    assign pixel_wr  = pixel_wr_q;
    assign pixel_x   = cur_x_q;
    assign pixel_y   = cur_y_q;
    assign draw_done = draw_done_q;
    assign busy      = busy_q;

endmodule
